// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: state encoding, byte width,
// and the lock-timeout counter width helper.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] IDLE_S = 2'd0;
  localparam logic [1:0] HOLD_S = 2'd1;
  localparam logic [1:0] GAP_S  = 2'd2;
  localparam logic [1:0] LOCK_S = 2'd3;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the UART transmit arbiter.
// master = arbiter side, slave = requesters plus transmitter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [BYTE_W*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ-1:0]        req_ack_o;
  logic [BYTE_W-1:0]         dout_8b_o;
  logic                      dout_valid_o;
  logic                      tx_busy_i;
  logic [NUM_REQ-1:0]        grant_o;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, tx_busy_i,
    output req_ack_o, dout_8b_o, dout_valid_o, grant_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, tx_busy_i,
    input  req_ack_o, dout_8b_o, dout_valid_o, grant_o
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping from NUM_REQ-1 back to 0.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IW-1:0]      win_idx,
  output logic               win_any
);

  int unsigned   sum;
  logic [IW-1:0] pos;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    sum     = 0;
    pos     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = 32'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      pos = IW'(sum);
      if (!win_any && req[pos]) begin
        win_any     = 1'b1;
        win_oh[pos] = 1'b1;
        win_idx     = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit byte path between NUM_REQ
// sources. Define UART_ARB_LOCK_EN to keep the grant until a byte with last=1.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input logic              clk_i,
  input logic              rst_i,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [1:0]         state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] pick_req;
  logic               win_any;
  logic               issue;
  logic [BYTE_W-1:0]  win_byte;

`ifdef UART_ARB_LOCK_EN
  localparam int unsigned CW = cnt_width(LOCK_TIMEOUT);
  logic [CW-1:0] cnt_q;
  logic          last_q;
  logic          owner_valid;

  // While locked only the current owner is offered to the picker, so the
  // normal issue path also handles locked issue and pointer update.
  assign owner_valid = |(bus.req_valid_i & bus.grant_o);
  assign pick_req    = (state_q == LOCK_S) ? (bus.req_valid_i & bus.grant_o) : bus.req_valid_i;
  assign issue       = ((state_q == IDLE_S) || (state_q == LOCK_S)) && win_any && !bus.tx_busy_i;
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.req_last_i, LOCK_TIMEOUT[0]};
  assign pick_req   = bus.req_valid_i;
  assign issue      = (state_q == IDLE_S) && win_any && !bus.tx_busy_i;
`endif

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (pick_req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign next_ptr = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);

  always_comb begin
    win_byte = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_oh[k]) win_byte = win_byte | bus.req_data_i[k*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE_S;
      ptr_q            <= '0;
      bus.grant_o      <= '0;
      bus.dout_8b_o    <= '0;
      bus.dout_valid_o <= 1'b0;
      bus.req_ack_o    <= '0;
`ifdef UART_ARB_LOCK_EN
      cnt_q            <= '0;
      last_q           <= 1'b0;
`endif
    end else begin
      bus.dout_valid_o <= 1'b0;
      bus.req_ack_o    <= '0;
      if (issue) begin
        bus.grant_o      <= win_oh;
        bus.dout_8b_o    <= win_byte;
        bus.dout_valid_o <= 1'b1;
        bus.req_ack_o    <= win_oh;
        ptr_q            <= next_ptr;
        state_q          <= HOLD_S;
`ifdef UART_ARB_LOCK_EN
        cnt_q            <= '0;
        last_q           <= |(bus.req_last_i & win_oh);
`endif
      end else begin
        case (state_q)
          IDLE_S: state_q <= IDLE_S;
          HOLD_S: state_q <= GAP_S;
`ifdef UART_ARB_LOCK_EN
          GAP_S:  state_q <= last_q ? IDLE_S : LOCK_S;
          LOCK_S: begin
            if (!owner_valid) begin
              if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                state_q <= IDLE_S;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
`else
          GAP_S:  state_q <= IDLE_S;
`endif
          default: state_q <= IDLE_S;
        endcase
      end
    end
  end

endmodule
